// File: rtl/psum_binarize_packer.sv
// psum_binarize_packer
//
// Consumer end of a PE column. Each accepted partial sum is binarized against
// a per-channel threshold (folded batch-norm + sign, optional inversion for a
// negative BN scale). The resulting bits are packed LSB-first into PACK-bit
// activation words, which are in the same format as a PE activation window.
// A 2-entry output FIFO absorbs downstream backpressure.
//
// Handshake rule used on both sides: a transfer happens on a rising clk_in edge
// where valid and ready are both 1. Once valid is raised, the producer holds its
// payload until the transfer. Ready here comes only from registered state and
// never depends combinationally on the matching valid or on act_ready_in.
//
// Ports
//   clk_in          clock, rising edge
//   rst_in          asynchronous active-low reset
//   psum_valid_in   psum_in / last_in valid this cycle
//   psum_in         signed partial sum from the PE column (WIDTH)
//   last_in         final psum of a row; closes the current word
//   psum_ready_out  block accepts a psum this cycle (FIFO not full)
//   threshold_in    signed threshold; held static while a word fills
//   invert_in       flip output bit; held static while a word fills
//   act_valid_out   FIFO head valid
//   act_out         packed activation word (bit=1 means +1)
//   act_count_out   number of meaningful bits in act_out, 1..PACK
//   act_last_out    word was closed by last_in
//   act_ready_in    downstream accepts the head word
//   dbg_state       packer FSM state (0 = FILL, 1 = CLOSE pending)
module psum_binarize_packer #(
    parameter int WIDTH = 14,
    parameter int PACK  = 27,
    parameter int CNT_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             psum_valid_in,
    input  logic [WIDTH-1:0] psum_in,
    input  logic             last_in,
    output logic             psum_ready_out,
    input  logic [WIDTH-1:0] threshold_in,
    input  logic             invert_in,
    output logic             act_valid_out,
    output logic [PACK-1:0]  act_out,
    output logic [CNT_W-1:0] act_count_out,
    output logic             act_last_out,
    input  logic             act_ready_in,
    output logic             dbg_state
);

    // S_FILL: the next accepted psum only appends a bit unless last_in is set.
    // S_CLOSE: the counter sits at PACK-1, so the next accepted psum closes the word.
    typedef enum logic {
        S_FILL  = 1'b0,
        S_CLOSE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [PACK-1:0]  word_q;

    // FIFO: head slot drives the outputs directly. Both slots read as zero
    // when they are unoccupied, so an empty FIFO drives zeros.
    logic [1:0]       fifo_cnt_q;
    logic [PACK-1:0]  head_word_q, tail_word_q;
    logic [CNT_W-1:0] head_cnt_q, tail_cnt_q;
    logic             head_last_q, tail_last_q;

    // Holds psum_ready_out low while reset is asserted and until the first edge after release.
    logic             run_q;

    logic             accept;
    logic             bit_b;
    logic             closing;
    logic             push, pop;
    logic [PACK-1:0]  word_bit;
    logic [CNT_W-1:0] cnt_inc;

    assign act_valid_out  = (fifo_cnt_q != 2'd0);
    assign act_out        = head_word_q;
    assign act_count_out  = head_cnt_q;
    assign act_last_out   = head_last_q;
    assign psum_ready_out = run_q && (fifo_cnt_q != 2'd2);
    assign dbg_state      = state_q;

    always_comb begin
        accept   = psum_valid_in && psum_ready_out;
        // Signed compare at full width. Equality maps to +1 before inversion.
        bit_b    = ($signed(psum_in) >= $signed(threshold_in)) ^ invert_in;
        word_bit = word_q | (PACK'(bit_b) << cnt_q);
        cnt_inc  = cnt_q + CNT_W'(1);
        closing  = accept && ((state_q == S_CLOSE) || last_in);
        push     = closing;
        pop      = act_valid_out && act_ready_in;

        state_d = state_q;
        if (accept) begin
            if (closing) begin
                state_d = S_FILL;
            end else if (cnt_q == CNT_W'(PACK - 2)) begin
                state_d = S_CLOSE;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            word_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (closing) begin
                // Start the next word immediately, so no bubble cycle follows a close.
                cnt_q  <= '0;
                word_q <= '0;
            end else if (accept) begin
                cnt_q  <= cnt_inc;
                word_q <= word_bit;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fifo_cnt_q  <= 2'd0;
            head_word_q <= '0;
            head_cnt_q  <= '0;
            head_last_q <= 1'b0;
            tail_word_q <= '0;
            tail_cnt_q  <= '0;
            tail_last_q <= 1'b0;
        end else begin
            if (push && !pop) begin
                if (fifo_cnt_q == 2'd0) begin
                    head_word_q <= word_bit;
                    head_cnt_q  <= cnt_inc;
                    head_last_q <= last_in;
                end else begin
                    tail_word_q <= word_bit;
                    tail_cnt_q  <= cnt_inc;
                    tail_last_q <= last_in;
                end
                fifo_cnt_q <= fifo_cnt_q + 2'd1;
            end else if (pop && !push) begin
                // The tail moves up. It is zero when it was empty.
                head_word_q <= tail_word_q;
                head_cnt_q  <= tail_cnt_q;
                head_last_q <= tail_last_q;
                tail_word_q <= '0;
                tail_cnt_q  <= '0;
                tail_last_q <= 1'b0;
                fifo_cnt_q  <= fifo_cnt_q - 2'd1;
            end else if (push && pop) begin
                if (fifo_cnt_q == 2'd1) begin
                    head_word_q <= word_bit;
                    head_cnt_q  <= cnt_inc;
                    head_last_q <= last_in;
                end else begin
                    head_word_q <= tail_word_q;
                    head_cnt_q  <= tail_cnt_q;
                    head_last_q <= tail_last_q;
                    tail_word_q <= word_bit;
                    tail_cnt_q  <= cnt_inc;
                    tail_last_q <= last_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_binarize_packer.sv
module tb_psum_binarize_packer;

  localparam int WIDTH = 14;
  localparam int PACK  = 27;
  localparam int CNT_W = 5;
  localparam int EW    = PACK + CNT_W + 1;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             psum_valid_in;
  logic [WIDTH-1:0] psum_in;
  logic             last_in;
  logic             psum_ready_out;
  logic [WIDTH-1:0] threshold_in;
  logic             invert_in;
  logic             act_valid_out;
  logic [PACK-1:0]  act_out;
  logic [CNT_W-1:0] act_count_out;
  logic             act_last_out;
  logic             act_ready_in;
  logic             dbg_state;

  int checks = 0;
  int failures = 0;

  // Scoreboard entries are {last, count, word}.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];

  // Reference model: the bits of the word still open, as a plain integer.
  longint m_val  = 0;
  int     m_bits = 0;
  bit     rnd_done = 0;

  psum_binarize_packer #(.WIDTH(WIDTH), .PACK(PACK), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .psum_valid_in(psum_valid_in), .psum_in(psum_in), .last_in(last_in),
    .psum_ready_out(psum_ready_out),
    .threshold_in(threshold_in), .invert_in(invert_in),
    .act_valid_out(act_valid_out), .act_out(act_out),
    .act_count_out(act_count_out), .act_last_out(act_last_out),
    .act_ready_in(act_ready_in), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // Words leaving the FIFO. These are captured at the negative edge, away from the pop edge.
  always @(negedge clk_in) begin
    if (rst_in && act_valid_out && act_ready_in)
      got_q.push_back({act_last_out, act_count_out, act_out});
  end

  // ---------------- reference model ----------------
  function automatic bit ref_bit(int p, int t, bit inv);
    return (p >= t) != inv;
  endfunction

  task automatic model_push(int p, int t, bit inv, bit l);
    if (ref_bit(p, t, inv)) m_val = m_val + (longint'(1) << m_bits);
    m_bits = m_bits + 1;
    if (m_bits == PACK || l) begin
      exp_q.push_back({l, CNT_W'(m_bits), PACK'(m_val)});
      m_val = 0;
      m_bits = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Call at a time 1 unit after a rising edge. The task returns 1 unit after the accepting edge.
  task automatic send(int p, bit l);
    int waited;
    waited = 0;
    psum_valid_in = 1'b1;
    psum_in = WIDTH'(p);
    last_in = l;
    while (psum_ready_out !== 1'b1 && waited < 300) begin
      @(posedge clk_in); #1;
      waited++;
    end
    checks++;
    if (waited >= 300) begin
      failures++;
      $display("FAIL send_timeout psum_ready_out=%b required=1", psum_ready_out);
      psum_valid_in = 1'b0;
      last_in = 1'b0;
      return;
    end
    @(posedge clk_in); #1;
    psum_valid_in = 1'b0;
    last_in = 1'b0;
    model_push(p, int'($signed(threshold_in)), invert_in, l);
  endtask

  task automatic wait_drain(int n);
    int waited;
    waited = 0;
    while (got_q.size() < n && waited < 500) begin
      @(posedge clk_in); #1;
      waited++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_in = 1'b0;
    psum_valid_in = 1'b0; psum_in = '0; last_in = 1'b0;
    threshold_in = '0; invert_in = 1'b0; act_ready_in = 1'b0;
    #12;
    checks++;
    if ({act_valid_out, act_out, act_count_out, act_last_out, psum_ready_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b act=%h cnt=%0d last=%b ready=%b required all 0",
               act_valid_out, act_out, act_count_out, act_last_out, psum_ready_out);
    end
    @(negedge clk_in); rst_in = 1'b1;
    @(posedge clk_in); #1;
    checks++;
    if (psum_ready_out !== 1'b1 || act_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_release ready=%b valid=%b required ready=1 valid=0",
               psum_ready_out, act_valid_out);
    end
  endtask

  task automatic test_alternating;
    logic [EW-1:0] e, g;
    threshold_in = '0; invert_in = 1'b0; act_ready_in = 1'b1;
    for (int k = 0; k < PACK; k++) begin
      send((k % 2 == 0) ? 5 : -5, 1'b0);
      if (k == PACK - 2) begin
        checks++;
        if (act_valid_out !== 1'b0) begin
          failures++;
          $display("FAIL alt_early_valid valid=%b required=0", act_valid_out);
        end
      end
    end
    checks++;
    if (act_valid_out !== 1'b1 || act_out !== 27'h5555555 || act_count_out !== 5'd27 || act_last_out !== 1'b0) begin
      failures++;
      $display("FAIL alt_word valid=%b act=%h cnt=%0d last=%b required 1/5555555/27/0",
               act_valid_out, act_out, act_count_out, act_last_out);
    end
    wait_drain(exp_q.size());
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL alt_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL alt_sb got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_threshold;
    logic [EW-1:0] e, g;
    threshold_in = WIDTH'(100); invert_in = 1'b0; act_ready_in = 1'b1;
    send(100, 1'b0); send(99, 1'b0); send(100, 1'b0); send(99, 1'b1);
    checks++;
    if (act_valid_out !== 1'b1 || act_out !== 27'h0000005 || act_count_out !== 5'd4 || act_last_out !== 1'b1) begin
      failures++;
      $display("FAIL thr_word valid=%b act=%h cnt=%0d last=%b required 1/0000005/4/1",
               act_valid_out, act_out, act_count_out, act_last_out);
    end
    invert_in = 1'b1;
    send(100, 1'b0); send(99, 1'b1);
    checks++;
    if (act_valid_out !== 1'b1 || act_out !== 27'h0000002 || act_count_out !== 5'd2 || act_last_out !== 1'b1) begin
      failures++;
      $display("FAIL thr_invert valid=%b act=%h cnt=%0d last=%b required 1/0000002/2/1",
               act_valid_out, act_out, act_count_out, act_last_out);
    end
    invert_in = 1'b0;
    wait_drain(exp_q.size());
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL thr_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL thr_sb got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_signed;
    threshold_in = WIDTH'(8191); invert_in = 1'b0; act_ready_in = 1'b1;
    send(-8192, 1'b1);
    checks++;
    if (act_valid_out !== 1'b1 || act_out !== 27'h0 || act_count_out !== 5'd1) begin
      failures++;
      $display("FAIL signed_neg valid=%b act=%h cnt=%0d required 1/0000000/1",
               act_valid_out, act_out, act_count_out);
    end
    threshold_in = WIDTH'(-8192);
    send(8191, 1'b1);
    checks++;
    if (act_valid_out !== 1'b1 || act_out !== 27'h1 || act_count_out !== 5'd1) begin
      failures++;
      $display("FAIL signed_pos valid=%b act=%h cnt=%0d required 1/0000001/1",
               act_valid_out, act_out, act_count_out);
    end
    wait_drain(2);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure;
    logic [EW-1:0] e, g;
    logic [PACK-1:0] held;
    threshold_in = '0; invert_in = 1'b0; act_ready_in = 1'b0;
    for (int k = 0; k < 2 * PACK; k++) begin
      send(int'($urandom_range(0, 8191)), 1'b0);
      if (k == 2 * PACK - 2) begin
        checks++;
        if (psum_ready_out !== 1'b1) begin
          failures++;
          $display("FAIL bp_ready_early ready=%b required=1", psum_ready_out);
        end
      end
    end
    checks++;
    if (psum_ready_out !== 1'b0 || act_valid_out !== 1'b1 || act_out !== 27'h7FFFFFF || act_count_out !== 5'd27) begin
      failures++;
      $display("FAIL bp_full ready=%b valid=%b act=%h cnt=%0d required 0/1/7ffffff/27",
               psum_ready_out, act_valid_out, act_out, act_count_out);
    end
    held = act_out;
    psum_valid_in = 1'b1; psum_in = WIDTH'(1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_in); #1;
      checks++;
      if (act_out !== held || act_valid_out !== 1'b1 || psum_ready_out !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold act=%h valid=%b ready=%b required %h/1/0",
                 act_out, act_valid_out, psum_ready_out, held);
      end
    end
    psum_valid_in = 1'b0;
    act_ready_in = 1'b1;
    @(posedge clk_in); #1;
    checks++;
    if (psum_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL bp_reassert ready=%b required=1", psum_ready_out);
    end
    for (int k = 0; k < PACK; k++) send(int'($urandom_range(0, 8191)), 1'b0);
    wait_drain(3);
    checks++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      failures++;
      $display("FAIL bp_count got=%0d required=3", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL bp_sb got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_last_27;
    logic [EW-1:0] e, g;
    threshold_in = WIDTH'($urandom_range(0, 400) - 200); invert_in = 1'($urandom_range(0, 1));
    act_ready_in = 1'b1;
    for (int k = 0; k < PACK - 1; k++) send(int'($urandom_range(0, 1000)) - 500, 1'b0);
    send(int'($urandom_range(0, 1000)) - 500, 1'b1);
    checks++;
    if (exp_q.size() != 1 || act_valid_out !== 1'b1 || {act_last_out, act_count_out, act_out} !== exp_q[$]
        || act_count_out !== 5'd27 || act_last_out !== 1'b1 || psum_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL last27_word valid=%b word=%h cnt=%0d last=%b ready=%b required word=%h cnt=27 last=1 ready=1",
               act_valid_out, act_out, act_count_out, act_last_out, psum_ready_out, exp_q[$]);
    end
    send(int'($urandom_range(0, 1000)) - 500, 1'b1);
    checks++;
    if (act_valid_out !== 1'b1 || {act_last_out, act_count_out, act_out} !== exp_q[$] || act_count_out !== 5'd1) begin
      failures++;
      $display("FAIL last27_next got=%h required=%h", {act_last_out, act_count_out, act_out}, exp_q[$]);
    end
    wait_drain(exp_q.size());
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL last27_count got=%0d required=2", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL last27_sb got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [EW-1:0] e, g;
    threshold_in = '0; invert_in = 1'b0; act_ready_in = 1'b0;
    send(1, 1'b0); send(-1, 1'b1);
    for (int k = 0; k < 10; k++) send(int'($urandom_range(0, 2000)) - 1000, 1'b0);
    checks++;
    if (act_valid_out !== 1'b1 || act_out !== 27'h1) begin
      failures++;
      $display("FAIL rstmid_pre valid=%b act=%h required 1/0000001", act_valid_out, act_out);
    end
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if ({act_valid_out, act_out, act_count_out, act_last_out, psum_ready_out} !== '0) begin
      failures++;
      $display("FAIL rstmid_async valid=%b act=%h cnt=%0d last=%b ready=%b required all 0",
               act_valid_out, act_out, act_count_out, act_last_out, psum_ready_out);
    end
    exp_q.delete(); got_q.delete(); m_val = 0; m_bits = 0;
    @(posedge clk_in); #1;
    checks++;
    if (psum_ready_out !== 1'b0 || act_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_held ready=%b valid=%b required 0/0", psum_ready_out, act_valid_out);
    end
    #2 rst_in = 1'b1;
    @(posedge clk_in); #1;
    act_ready_in = 1'b1;
    send(1, 1'b0); send(1, 1'b0); send(1, 1'b1);
    checks++;
    if (act_valid_out !== 1'b1 || act_out !== 27'h7 || act_count_out !== 5'd3 || act_last_out !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_after valid=%b act=%h cnt=%0d last=%b required 1/0000007/3/1",
               act_valid_out, act_out, act_count_out, act_last_out);
    end
    wait_drain(1);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL rstmid_count got=%0d required=1", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL rstmid_sb got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random;
    logic [EW-1:0] e, g;
    int n;
    rnd_done = 0;
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          if (m_bits == 0) begin
            threshold_in = WIDTH'(int'($urandom_range(0, 16383)) - 8192);
            invert_in = 1'($urandom_range(0, 1));
          end
          send(int'($urandom_range(0, 16383)) - 8192, ($urandom_range(0, 9) == 0));
        end
        send(0, 1'b1);
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk_in); #1;
          act_ready_in = ($urandom_range(0, 3) != 0);
        end
      end
    join
    act_ready_in = 1'b1;
    n = exp_q.size();
    wait_drain(n);
    checks++;
    if (got_q.size() != n) begin
      failures++;
      $display("FAIL rand_count got=%0d required=%0d", got_q.size(), n);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL rand_sb got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_alternating();
    test_threshold();
    test_signed();
    test_backpressure();
    test_last_27();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_binarize_packer.md
Name: psum_binarize_packer

Overview:
- Consumer end of the PE column interface: takes the accumulated partial sum leaving the last PE of a column and binarizes it against a per-channel threshold (folded batch-norm + sign).
- Packs the resulting ±1 bits LSB-first into 27-bit activation words. Each word is the same format as a PE activation_in window, for the next layer.
- A 2-entry output FIFO with valid/ready absorbs downstream backpressure.

Parameters:
- WIDTH, 14, partial-sum and threshold width (two's complement).
- PACK, 27, bits per packed activation word.
- CNT_W, 5, width of bit counter / act_count_out; must satisfy 2^CNT_W > PACK.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous active-low reset.
- psum_valid_in  input  1  psum_in/last_in valid this cycle.
- psum_in  input  WIDTH  signed partial sum from the PE column.
- last_in  input  1  marks the final psum of a row; qualified by psum_valid_in.
- psum_ready_out  output  1  block accepts a psum this cycle.
- threshold_in  input  WIDTH  signed threshold; static while a word fills.
- invert_in  input  1  flip output bit (negative BN scale); static while a word fills.
- act_valid_out  output  1  FIFO head valid.
- act_out  output  PACK  packed activation word (bit=1 means +1).
- act_count_out  output  CNT_W  number of meaningful bits in act_out, 1..PACK.
- act_last_out  output  1  word closed by last_in.
- act_ready_in  input  1  downstream accepts head word.

Behaviour:
- Reset (rst_in low, asynchronous): bit counter=0, shift word=0, FIFO empty. Outputs: act_valid_out=0, act_out=0, act_count_out=0, act_last_out=0, psum_ready_out=0 while rst_in is low. After release, psum_ready_out=1 from the first clock edge. Reset mid-word discards the partial word and all FIFO contents.
- Accept: a psum is accepted on an edge where psum_valid_in && psum_ready_out.
- psum_ready_out = FIFO not full (count<2), registered state only. There is no combinational path from act_ready_in.
- Bit: b = ($signed(psum_in) >= $signed(threshold_in)) ^ invert_in. Equality yields 1 before inversion. The comparison is signed at full WIDTH, with no truncation.
- Packing: the k-th accepted psum of a word (k=0..PACK-1) sets bit k. Bits not yet written are 0.
- Two-state FSM:
  - FILL: counter<PACK-1 and no last. Accept writes the bit and increments the counter.
  - CLOSE: the accepted psum has counter==PACK-1 or last_in=1. Push {word|bit, count=counter+1, last=last_in} into the FIFO on that edge. Counter and shift word clear to 0, so the next accepted psum starts a new word with no bubble cycle.
- last_in on the 27th bit: exactly one word, count=27, last=1.
- last_in while psum_valid_in=0: ignored.
- Latency: a completed word appears on act_out/act_valid_out the cycle after its closing psum is accepted (FIFO empty case).
- FIFO: 2 entries, registered head outputs. Pop on act_valid_out && act_ready_in.
- Simultaneous push and pop:
  - Count unchanged.
  - Ordering preserved.
  - When count=1, the pushed word becomes the new head the next cycle.
- Push can only occur when count<2; since psum_ready_out=0 when full, overflow is impossible.
- Hold: act_out/act_count_out/act_last_out hold stable while act_valid_out=1 and act_ready_in=0.
- When FIFO empty: act_out, act_count_out and act_last_out drive 0.

Test Plan:
1. Alternating psum +5/-5 ×27, thr=0, invert=0, act_ready_in=1 → one word, one cycle after the 27th accept: act_out=27'h5555555, act_count_out=27, act_last_out=0.
2. thr=100: psum 100 → bit 1; psum 99 → bit 0; same pair with invert=1 → 0, 1. Word closed with last_in after 4 psums (100, 99, 100, 99), invert=0 → act_out=27'h0000005, count=4, last=1.
3. psum=-8192 (14'h2000), thr=8191 → bit 0; psum=8191, thr=-8192 → bit 1. This checks the comparison is signed, not unsigned.
4. Backpressure:
   - Hold act_ready_in=0 and feed 81 all-positive psums (thr=0).
   - psum_ready_out drops the cycle after the 54th accept. Two words of 27'h7FFFFFF are held; act_out stays stable.
   - Raise act_ready_in → words drain in order, psum_ready_out reasserts, the remaining 27 psums complete a third word.
5. last_in coincident with the 27th psum → single word, count=27, last=1. The next psum lands in bit 0 of a new word with no idle cycle.
6. After 10 accepted psums, pull rst_in low mid-cycle:
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After release, 3 psums + last_in → act_out=27'h0000007, count=3.
